// File: rtl/mmu_walk_arbiter_if.sv
// Walker-side handshake bundle between the TLB miss arbiter (master) and the page-table walker (slave).
interface mmu_walk_arbiter_if #(
  parameter int XLEN = 64
);
  logic            WalkReq;
  logic [XLEN-1:0] WalkVAdr;
  logic            WalkIsInstr;
  logic            WalkAck;
  logic            WalkDone;
  logic [XLEN-1:0] WalkPTE;
  logic [1:0]      WalkPageType;
  logic            WalkFault;

  modport master (
    output WalkReq, WalkVAdr, WalkIsInstr,
    input  WalkAck, WalkDone, WalkPTE, WalkPageType, WalkFault
  );

  modport slave (
    input  WalkReq, WalkVAdr, WalkIsInstr,
    output WalkAck, WalkDone, WalkPTE, WalkPageType, WalkFault
  );
endinterface

// File: rtl/mmu_walk_arbiter.sv
// Shares one page-table walker between ITLB and DTLB misses; returns fills/faults as one-cycle strobes.
// Optional: define MMU_WALK_WATCHDOG_EN to force a fault on walks lasting WATCHDOG_CYCLES cycles.
module mmu_walk_arbiter #(
  parameter int XLEN            = 64,
  parameter int WATCHDOG_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  mmu_walk_arbiter_if.master walk,
  input  logic               ITLBMissF,
  input  logic               DTLBMissM,
  input  logic [XLEN-1:0]    IVAdrF,
  input  logic [XLEN-1:0]    DVAdrM,
  input  logic               TLBFlush,
  output logic               ITLBWriteF,
  output logic               DTLBWriteM,
  output logic [XLEN-1:0]    PTE,
  output logic [1:0]         PageTypeWriteVal,
  output logic               InstrWalkFaultF,
  output logic               DataWalkFaultM,
  output logic               WalkBusy
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, ABORT} state_t;

  state_t          state_q;
  logic [XLEN-1:0] vadr_q, pte_q;
  logic [1:0]      pt_q;
  logic            instr_q;
  logic            iwr_q, dwr_q, iflt_q, dflt_q;
  logic            tmo, wbusy;

`ifdef MMU_WALK_WATCHDOG_EN
  localparam int             WDW    = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIM = WDW'(WATCHDOG_CYCLES);

  logic [WDW-1:0] wd_q, wd_d;
  logic           wbusy_q, wbusy_d;

  // REQ is only entered from IDLE, so holding the count at zero in IDLE clears it on entry.
  always_comb begin
    wd_d    = wd_q;
    wbusy_d = wbusy_q;
    if (state_q == IDLE) wd_d = '0;
    else if ((state_q == REQ || state_q == WAIT) && wd_q != WD_LIM) wd_d = wd_q + 1'b1;
    if (state_q == REQ && walk.WalkAck) wbusy_d = 1'b1;
    if (walk.WalkDone) wbusy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q    <= '0;
      wbusy_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      wbusy_q <= wbusy_d;
    end
  end

  assign tmo   = (state_q == REQ || state_q == WAIT) && (wd_d == WD_LIM);
  assign wbusy = wbusy_q;
`else
  logic unused_wd;
  assign unused_wd = ^WATCHDOG_CYCLES;
  assign tmo       = 1'b0;
  assign wbusy     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      vadr_q  <= '0;
      instr_q <= 1'b0;
      pte_q   <= '0;
      pt_q    <= '0;
      iwr_q   <= 1'b0;
      dwr_q   <= 1'b0;
      iflt_q  <= 1'b0;
      dflt_q  <= 1'b0;
    end else begin
      iwr_q  <= 1'b0;
      dwr_q  <= 1'b0;
      iflt_q <= 1'b0;
      dflt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // DTLB wins: the data access is older in the pipeline.
          if ((ITLBMissF | DTLBMissM) & ~TLBFlush) begin
            state_q <= REQ;
            instr_q <= ~DTLBMissM;
            vadr_q  <= DTLBMissM ? DVAdrM : IVAdrF;
          end
        end
        REQ: begin
          if (TLBFlush) state_q <= walk.WalkAck ? ABORT : IDLE;
          else if (tmo) begin
            state_q <= FILL;
            iflt_q  <= instr_q;
            dflt_q  <= ~instr_q;
          end else if (walk.WalkAck) state_q <= WAIT;
        end
        WAIT: begin
          if (TLBFlush) state_q <= walk.WalkDone ? IDLE : ABORT;
          else if (tmo) begin
            state_q <= FILL;
            iflt_q  <= instr_q;
            dflt_q  <= ~instr_q;
          end else if (walk.WalkDone) begin
            state_q <= FILL;
            pte_q   <= walk.WalkPTE;
            pt_q    <= walk.WalkPageType;
            iwr_q   <= instr_q & ~walk.WalkFault;
            dwr_q   <= ~instr_q & ~walk.WalkFault;
            iflt_q  <= instr_q & walk.WalkFault;
            dflt_q  <= ~instr_q & walk.WalkFault;
          end
        end
        FILL:    state_q <= (wbusy && !walk.WalkDone) ? ABORT : IDLE;
        ABORT:   if (walk.WalkDone) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign walk.WalkReq     = (state_q == REQ);
  assign walk.WalkVAdr    = vadr_q;
  assign walk.WalkIsInstr = instr_q;
  assign WalkBusy         = (state_q != IDLE);
  assign PTE              = pte_q;
  assign PageTypeWriteVal = pt_q;

  // A flush landing on the FILL cycle must keep a stale translation out of the TLBs.
  assign ITLBWriteF      = iwr_q  & ~TLBFlush;
  assign DTLBWriteM      = dwr_q  & ~TLBFlush;
  assign InstrWalkFaultF = iflt_q & ~TLBFlush;
  assign DataWalkFaultM  = dflt_q & ~TLBFlush;
endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Self-checking bench for mmu_walk_arbiter: vector table, flush/reset sequences, randomized walks vs a transaction model.
module tb_mmu_walk_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ITLBMissF, DTLBMissM, TLBFlush;
  logic [63:0] IVAdrF, DVAdrM;
  logic        ITLBWriteF, DTLBWriteM, InstrWalkFaultF, DataWalkFaultM, WalkBusy;
  logic [63:0] PTE;
  logic [1:0]  PageTypeWriteVal;
  int          n_cmp = 0, n_bad = 0, iwr_cnt = 0;
  logic        dh = 1'b0, ih = 1'b0;

  mmu_walk_arbiter_if #(.XLEN(64)) wif();

  mmu_walk_arbiter #(.XLEN(64), .WATCHDOG_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .walk(wif),
    .ITLBMissF(ITLBMissF), .DTLBMissM(DTLBMissM), .IVAdrF(IVAdrF), .DVAdrM(DVAdrM),
    .TLBFlush(TLBFlush), .ITLBWriteF(ITLBWriteF), .DTLBWriteM(DTLBWriteM), .PTE(PTE),
    .PageTypeWriteVal(PageTypeWriteVal), .InstrWalkFaultF(InstrWalkFaultF),
    .DataWalkFaultM(DataWalkFaultM), .WalkBusy(WalkBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic strobe_chk(input string nm, input logic iw, input logic dw, input logic fi, input logic fd);
    chk({nm, "_itlbwr"}, ITLBWriteF, iw);
    chk({nm, "_dtlbwr"}, DTLBWriteM, dw);
    chk({nm, "_ifault"}, InstrWalkFaultF, fi);
    chk({nm, "_dfault"}, DataWalkFaultM, fd);
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_req"}, wif.WalkReq, 1'b0);
    chk({nm, "_busy"}, WalkBusy, 1'b0);
    strobe_chk(nm, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // A miss may only drop in the cycle its fill/fault strobe or a flush is seen.
  always @(posedge clk) begin
    if (!reset) begin
      dh <= 1'b0;
      ih <= 1'b0;
    end else begin
      if (dh && !DTLBMissM) chk("dmiss_hold", DTLBWriteM | DataWalkFaultM | TLBFlush, 1'b1);
      if (ih && !ITLBMissF) chk("imiss_hold", ITLBWriteF | InstrWalkFaultF | TLBFlush, 1'b1);
      dh <= DTLBMissM & ~(DTLBWriteM | DataWalkFaultM | TLBFlush);
      ih <= ITLBMissF & ~(ITLBWriteF | InstrWalkFaultF | TLBFlush);
      if (ITLBWriteF) iwr_cnt <= iwr_cnt + 1;
    end
  end

  // One walk starting with the REQ cycle at the next negedge; ends after checking the following IDLE cycle.
  task automatic walk(input int ack_dly, input int done_dly, input logic [63:0] pte, input logic [1:0] pt,
                      input logic flt, input logic ei, input logic [63:0] eva, input logic flush_fill,
                      input logic e_iw, input logic e_dw, input logic e_if, input logic e_df);
    for (int a = 0; a <= ack_dly; a++) begin
      @(negedge clk); wif.WalkAck = (a == ack_dly); #1;
      chk("req", wif.WalkReq, 1'b1);
      chk("req_busy", WalkBusy, 1'b1);
      chk("vadr", wif.WalkVAdr, eva);
      chk("isinstr", wif.WalkIsInstr, ei);
    end
    for (int d = 0; d <= done_dly; d++) begin
      @(negedge clk);
      wif.WalkAck      = 1'b0;
      wif.WalkDone     = (d == done_dly);
      wif.WalkPTE      = (d == done_dly) ? pte : {$urandom, $urandom};
      wif.WalkPageType = (d == done_dly) ? pt : 2'($urandom);
      wif.WalkFault    = (d == done_dly) ? flt : 1'($urandom);
      #1;
      chk("wait_req", wif.WalkReq, 1'b0);
      chk("wait_busy", WalkBusy, 1'b1);
      strobe_chk("wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    wif.WalkDone = 1'b0;
    TLBFlush     = flush_fill;
    if (ei) ITLBMissF = 1'b0; else DTLBMissM = 1'b0;
    #1;
    strobe_chk("fill", e_iw, e_dw, e_if, e_df);
    chk("fill_busy", WalkBusy, 1'b1);
    if (e_iw | e_dw) begin
      chk("fill_pte", PTE, pte);
      chk("fill_pt", PageTypeWriteVal, pt);
    end
    @(negedge clk); TLBFlush = 1'b0; #1;
    idle_chk("post_fill");
  endtask

  typedef struct {
    logic        dm, im;
    logic [63:0] dva, iva;
    int          ack_dly, done_dly;
    logic [63:0] pte;
    logic [1:0]  pt;
    logic        flt;
    logic        e_instr;
    logic [63:0] e_va;
    logic        e_iw, e_dw, e_if, e_df;
  } vec_t;

  vec_t tv[6];

  initial begin : main
    int          c0, ph, cnt;
    logic        ci, rflt;
    logic [63:0] cva, rpte;
    logic [1:0]  rpt;

    tv[0] = '{1, 0, 64'h0000_0040_1234_5000, 64'h1111, 1, 3, 64'h2000_04CF, 2'b01, 0, 0, 64'h0000_0040_1234_5000, 0, 1, 0, 0};
    tv[1] = '{0, 1, 64'h2222, 64'h0000_0000_8000_1000, 0, 0, 64'h1234_5678_9ABC_DEF1, 2'b00, 0, 1, 64'h0000_0000_8000_1000, 1, 0, 0, 0};
    tv[2] = '{0, 1, 64'h3333, 64'h0000_0000_7FFF_F000, 2, 1, 64'hDEAD_BEEF, 2'b10, 1, 1, 64'h0000_0000_7FFF_F000, 0, 0, 1, 0};
    tv[3] = '{1, 0, 64'hFFFF_FFFF_FFFF_F000, 64'h4444, 0, 4, 64'h0BAD_F00D, 2'b01, 1, 0, 64'hFFFF_FFFF_FFFF_F000, 0, 0, 0, 1};
    tv[4] = '{1, 0, 64'h0000_0000_0020_0000, 64'h5555, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 0, 0, 64'h0000_0000_0020_0000, 0, 1, 0, 0};
    tv[5] = '{0, 1, 64'h6666, 64'h0000_0001_0000_0000, 1, 2, 64'h0000_0000_0004_00C1, 2'b11, 0, 1, 64'h0000_0001_0000_0000, 1, 0, 0, 0};

    reset = 1'b0; ITLBMissF = 1'b0; DTLBMissM = 1'b0; TLBFlush = 1'b0; IVAdrF = '0; DVAdrM = '0;
    wif.WalkAck = 1'b0; wif.WalkDone = 1'b0; wif.WalkPTE = '0; wif.WalkPageType = '0; wif.WalkFault = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    idle_chk("rst");
    chk("rst_vadr", wif.WalkVAdr, 64'h0);
    chk("rst_isinstr", wif.WalkIsInstr, 1'b0);
    chk("rst_pte", PTE, 64'h0);
    chk("rst_pt", PageTypeWriteVal, 2'b00);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1; idle_chk("rst_rel");

    // Single-requester walks from the table.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      DTLBMissM = tv[i].dm; ITLBMissF = tv[i].im; DVAdrM = tv[i].dva; IVAdrF = tv[i].iva;
      #1; idle_chk("vec_c0");
      walk(tv[i].ack_dly, tv[i].done_dly, tv[i].pte, tv[i].pt, tv[i].flt, tv[i].e_instr, tv[i].e_va, 1'b0,
           tv[i].e_iw, tv[i].e_dw, tv[i].e_if, tv[i].e_df);
    end

    // Back-to-back: D first, then I issues two cycles after the D fill.
    c0 = iwr_cnt;
    @(negedge clk);
    DTLBMissM = 1'b1; ITLBMissF = 1'b1; DVAdrM = 64'h0000_0000_CAFE_0000; IVAdrF = 64'h0000_0000_0BEE_F000;
    #1; idle_chk("b2b_c0");
    walk(0, 1, 64'h0000_0000_1111_00CF, 2'b01, 1'b0, 1'b0, 64'h0000_0000_CAFE_0000, 1'b0, 0, 1, 0, 0);
    walk(1, 0, 64'h0000_0000_2222_00CB, 2'b00, 1'b0, 1'b1, 64'h0000_0000_0BEE_F000, 1'b0, 1, 0, 0, 0);
    chk("b2b_itlbwr_count", 64'(iwr_cnt - c0), 64'd1);

    // Flush in WAIT, done later: ABORT until done, nothing written.
    @(negedge clk); DTLBMissM = 1'b1; DVAdrM = 64'h0000_0000_00AB_C000; #1;
    @(negedge clk); #1; chk("fw_req1", wif.WalkReq, 1'b1);
    @(negedge clk); wif.WalkAck = 1'b1; #1; chk("fw_req2", wif.WalkReq, 1'b1);
    @(negedge clk); wif.WalkAck = 1'b0; #1; chk("fw_wait_req", wif.WalkReq, 1'b0);
    @(negedge clk); TLBFlush = 1'b1; DTLBMissM = 1'b0; #1; chk("fw_c4_busy", WalkBusy, 1'b1);
    for (int c = 5; c <= 8; c++) begin
      @(negedge clk);
      TLBFlush = (c == 6); wif.WalkDone = (c == 8); wif.WalkPTE = 64'h55; wif.WalkFault = 1'b0;
      #1;
      chk("fw_abort_busy", WalkBusy, 1'b1);
      chk("fw_abort_req", wif.WalkReq, 1'b0);
      strobe_chk("fw_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); wif.WalkDone = 1'b0; TLBFlush = 1'b0; #1; idle_chk("fw_c9");
    @(negedge clk); #1; idle_chk("fw_c10");

    // Flush in REQ without ack.
    @(negedge clk); DTLBMissM = 1'b1; #1;
    @(negedge clk); TLBFlush = 1'b1; DTLBMissM = 1'b0; #1; chk("fr_req", wif.WalkReq, 1'b1);
    @(negedge clk); TLBFlush = 1'b0; #1; idle_chk("fr_next");

    // Flush in REQ together with ack: walker owns the walk, so wait it out.
    @(negedge clk); ITLBMissF = 1'b1; IVAdrF = 64'h0000_0000_0001_2000; #1;
    @(negedge clk); TLBFlush = 1'b1; wif.WalkAck = 1'b1; ITLBMissF = 1'b0; #1;
    @(negedge clk); TLBFlush = 1'b0; wif.WalkAck = 1'b0; #1;
    chk("fra_busy", WalkBusy, 1'b1); chk("fra_req", wif.WalkReq, 1'b0);
    @(negedge clk); wif.WalkDone = 1'b1; wif.WalkFault = 1'b0; #1;
    chk("fra_busy2", WalkBusy, 1'b1); strobe_chk("fra", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); wif.WalkDone = 1'b0; #1; idle_chk("fra_end");

    // Flush coinciding with done in WAIT: result discarded.
    @(negedge clk); DTLBMissM = 1'b1; #1;
    @(negedge clk); wif.WalkAck = 1'b1; #1;
    @(negedge clk); wif.WalkAck = 1'b0; wif.WalkDone = 1'b1; wif.WalkFault = 1'b0; TLBFlush = 1'b1; DTLBMissM = 1'b0; #1;
    @(negedge clk); wif.WalkDone = 1'b0; TLBFlush = 1'b0; #1; idle_chk("fwd_next");

    // Flush in the FILL cycle suppresses the strobe.
    @(negedge clk); DTLBMissM = 1'b1; DVAdrM = 64'h0000_0000_0FF0_0000; #1;
    walk(0, 0, 64'h77, 2'b01, 1'b0, 1'b0, 64'h0000_0000_0FF0_0000, 1'b1, 0, 0, 0, 0);

    // Asynchronous reset mid-walk (WAIT), then during FILL.
    @(negedge clk); DTLBMissM = 1'b1; DVAdrM = 64'h0000_0000_0ABC_0000; #1;
    @(negedge clk); wif.WalkAck = 1'b1; #1;
    @(negedge clk); wif.WalkAck = 1'b0; #1; chk("ar_pre_busy", WalkBusy, 1'b1);
    #2; reset = 1'b0; DTLBMissM = 1'b0; #1;
    idle_chk("ar_wait");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); DTLBMissM = 1'b1; #1;
    @(negedge clk); wif.WalkAck = 1'b1; #1;
    @(negedge clk); wif.WalkAck = 1'b0; wif.WalkDone = 1'b1; wif.WalkPTE = 64'h99; wif.WalkFault = 1'b0; #1;
    @(negedge clk); wif.WalkDone = 1'b0; #1; chk("ar_fill_pre", DTLBWriteM, 1'b1);
    #2; reset = 1'b0; DTLBMissM = 1'b0; #1;
    idle_chk("ar_fill");
    chk("ar_fill_pte", PTE, 64'h0);
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1; idle_chk("ar_stay_idle");
    end

`ifdef MMU_WALK_WATCHDOG_EN
    // Ack without done: forced data fault 15 cycles after REQ entry, then ABORT until done.
    @(negedge clk); DTLBMissM = 1'b1; DVAdrM = 64'h0000_0000_0DDD_0000; #1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk); wif.WalkAck = (c == 1); #1;
      chk("wd_busy", WalkBusy, 1'b1);
      chk("wd_nofault", DataWalkFaultM, 1'b0);
    end
    @(negedge clk); wif.WalkAck = 1'b0; DTLBMissM = 1'b0; #1;
    strobe_chk("wd_fill", 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 17; c <= 20; c++) begin
      @(negedge clk); wif.WalkDone = (c == 20); wif.WalkFault = 1'b0; #1;
      chk("wd_abort_busy", WalkBusy, 1'b1);
      chk("wd_abort_req", wif.WalkReq, 1'b0);
      strobe_chk("wd_abort", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk); wif.WalkDone = 1'b0; #1; idle_chk("wd_end");
`endif

    // Randomized misses and walker timing, checked against a transaction-level model:
    // ph 0 = free, 1 = request outstanding, 2 = walking, 3 = result cycle.
    ph = 0; cnt = 0; ci = 1'b0; rflt = 1'b0; cva = '0; rpte = '0; rpt = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wif.WalkAck = 1'b0; wif.WalkDone = 1'b0;
      wif.WalkPTE = {$urandom, $urandom}; wif.WalkPageType = 2'($urandom); wif.WalkFault = 1'($urandom);
      if (ph == 1) wif.WalkAck = (cnt == 0);
      if (ph == 2 && cnt == 0) begin
        wif.WalkDone  = 1'b1;
        rflt          = ($urandom_range(3) == 0);
        wif.WalkFault = rflt;
        rpte          = wif.WalkPTE;
        rpt           = wif.WalkPageType;
      end
      if (ph == 3) begin
        if (ci) ITLBMissF = 1'b0; else DTLBMissM = 1'b0;
      end
      if (!DTLBMissM && !(ph == 3 && !ci) && $urandom_range(3) == 0) begin
        DTLBMissM = 1'b1; DVAdrM = {$urandom, $urandom};
      end
      if (!ITLBMissF && !(ph == 3 && ci) && $urandom_range(3) == 0) begin
        ITLBMissF = 1'b1; IVAdrF = {$urandom, $urandom};
      end
      #1;
      chk("r_busy", WalkBusy, ph != 0);
      chk("r_req", wif.WalkReq, ph == 1);
      if (ph == 1) begin
        chk("r_vadr", wif.WalkVAdr, cva);
        chk("r_isinstr", wif.WalkIsInstr, ci);
      end
      strobe_chk("r", (ph == 3) && ci && !rflt, (ph == 3) && !ci && !rflt,
                 (ph == 3) && ci && rflt, (ph == 3) && !ci && rflt);
      if (ph == 3 && !rflt) begin
        chk("r_pte", PTE, rpte);
        chk("r_pt", PageTypeWriteVal, rpt);
      end
      case (ph)
        0: if (DTLBMissM || ITLBMissF) begin
             ph  = 1;
             ci  = !DTLBMissM;
             cva = DTLBMissM ? DVAdrM : IVAdrF;
             cnt = $urandom_range(3);
           end
        1: if (cnt == 0) begin ph = 2; cnt = $urandom_range(5); end else cnt--;
        2: if (cnt == 0) ph = 3; else cnt--;
        default: ph = 0;
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach summary");
    $fatal(1, "timeout");
  end
endmodule
